operand_fwd_ctrl: RTL and testbench
===================================

# operand_fwd_ctrl

- Pipeline hazard and forwarding controller for the integer core.
- Tracks the destination register of every instruction in EX, MEM and WB.
- Produces the registered 2-bit select codes that drive the two operand `mux_4to1` instances in front of the ALU, and raises a one-cycle load-use stall.
- Sits between decode (ID) and the EX-stage operand muxes.

## Interface
Parameters:
- `REGADDR`, default 5: register address width.
- `CNTWIDTH`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: synchronous, active-high reset.
- `id_valid`  in  1: ID holds a valid instruction.
- `id_rs1`, `id_rs2`  in  REGADDR: source register addresses.
- `id_rs1_used`, `id_rs2_used`  in  1: the instruction reads that source.
- `id_rd`  in  REGADDR: destination register.
- `id_rd_we`  in  1: the instruction writes `id_rd`.
- `id_is_load`  in  1: the instruction is a load (result is available only at WB).
- `hold`  in  1: a multi-cycle EX unit is busy; freeze.
- `flush`  in  1: a branch was taken in EX; kill the ID instruction.
- `fwdA_sel`, `fwdB_sel`  out  2: registered select codes for the rs1 and rs2 operand muxes.
  - 00: register file.
  - 01: MEM-stage result.
  - 10: WB-stage result.
  - 11: regfile write-data bypass.
- `stall`  out  1: combinational; ID must hold its instruction this cycle.
- `stall_cnt`  out  CNTWIDTH: saturating count of stall cycles.

## Operation
Slot registers:
- There are three slots: EX, MEM and WB.
- Each slot holds {valid, rd, we, is_load}.
- On advance: WB←MEM, MEM←EX, and EX←ID (or a bubble).

A slot is a "producer" for source rs when all of the following hold: valid, we, rd==rs, rs≠0, and the matching `id_rsN_used` is 1.

Select computation happens in ID and is registered into EX with the instruction. Nearest producer wins:
- Producer in EX slot → 01.
- Else producer in MEM slot → 10.
- Else producer in WB slot → 11 (see Configuration).
- Else → 00.

Load-use rule:
- `stall` = `id_valid` & !`flush` & (EX-slot producer with is_load for rs1 or rs2).
- On a stall cycle: a bubble enters the EX slot, both selects register 00, and MEM and WB still advance.
- The next cycle, the load is in MEM and the select resolves to 10.

Priority: `rst` > `hold` > `flush` > `stall` > normal advance.
- `hold`: all slots, both selects and the counter keep their values. `stall` still evaluates combinationally.
- `flush` (without hold): a bubble enters EX, selects register 00, and MEM and WB advance. `stall` is forced to 0.
- `flush` together with `hold`: the flush is ignored. Upstream keeps `flush` asserted until `hold` drops.
- `id_valid`=0: a bubble enters EX and selects register 00.
- A bubble is a slot with valid=0. Its other fields are don't-care and never match.

Stall counter: increments by 1 on each cycle where `stall`=1 and `hold`=0, and saturates at all-ones.

## Timing
- Reset (synchronous, on the `rst` edge): all slot valid bits 0, `fwdA_sel`=`fwdB_sel`=00, `stall_cnt`=0.
- With reset asserted, `stall` reads 0 because the slots are invalid.
- A reset mid-operation discards all in-flight tracking on the next edge.
- Select latency: one cycle. Codes computed while the instruction is in ID are valid throughout its EX cycle(s), including held cycles.
- `stall` is combinational from the slot registers and the ID inputs, with no registered latency. It lasts exactly one cycle per load-use hazard unless `hold` extends it.
- rs1 and rs2 are evaluated independently. Both may forward from different stages in the same cycle.
- rs1==rs2 with a single producer gives identical codes on both outputs.

## Configuration
Macro `FWD_WB_BYPASS_EN`:
- Defined: a WB-slot producer yields code 11. Use this when the register file does not support write-before-read.
- Undefined: a WB-slot match yields 00 and code 11 is never emitted. The register file must then return the same-cycle write data internally.
- In both cases, EX and MEM matches and all stall behaviour are unchanged.

## Test plan
- Back-to-back ALU dependency: issue `add x5` then `sub` reading rs1=x5 → `fwdA_sel`=01 in the sub's EX cycle, `fwdB_sel`=00, `stall`=0.
- Distance 2 and 3: producer of x7, one unrelated instruction, then a consumer of x7 → 10. With two unrelated instructions in between → 11 if `FWD_WB_BYPASS_EN` is defined, else 00. Verify both builds.
- Load-use: `lw x3` then `add` reading rs2=x3 → `stall`=1 for one cycle, a bubble enters EX, then `fwdB_sel`=10 in the add's EX cycle, and `stall_cnt` goes 0→1.
- x0 and precedence: producer writes x0 and the consumer reads x0 → 00. Two producers of x9 in EX and MEM → 01 (nearest wins).
- Hold/flush/reset:
  - `hold` for 3 cycles during a forwarded EX → selects and slots are unchanged, and `stall_cnt` does not increment.
  - `flush` with the ID instruction a load-use consumer → `stall`=0 and a bubble enters EX.
  - `rst` asserted mid-stream → the next cycle shows selects 00 and `stall_cnt`=0.
- Saturation: with `CNTWIDTH`=4, force 20 load-use stalls → `stall_cnt` holds 4'hF.

Source files
------------

// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding and load-use hazard controller: tracks EX/MEM/WB destinations
// and registers the ALU operand mux selects. Optional WB bypass code via FWD_WB_BYPASS_EN.
module operand_fwd_ctrl #(
    parameter int REGADDR  = 5,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REGADDR-1:0]  id_rs1,
    input  logic [REGADDR-1:0]  id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REGADDR-1:0]  id_rd,
    input  logic                id_rd_we,
    input  logic                id_is_load,
    input  logic                hold,
    input  logic                flush,
    output logic [1:0]          fwdA_sel,
    output logic [1:0]          fwdB_sel,
    output logic                stall,
    output logic [CNTWIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_MEM = 2'b01,
        SEL_WB  = 2'b10,
        SEL_BYP = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [REGADDR-1:0] rd;
        logic               we;
        logic               is_load;
    } slot_t;

    slot_t    ex_q, mem_q, wb_q;
    slot_t    id_slot;
    fwd_sel_e sel_a, sel_b;
    logic     issue;

    function automatic logic produces(input slot_t s, input logic [REGADDR-1:0] rs,
                                      input logic used);
        return s.valid && s.we && (s.rd == rs) && (rs != '0) && used;
    endfunction

    // The instruction now in EX will be in MEM when the consumer reaches EX, hence 01.
    function automatic fwd_sel_e pick(input slot_t ex_s, input slot_t mem_s, input slot_t wb_s,
                                      input logic [REGADDR-1:0] rs, input logic used);
        fwd_sel_e sel;
        sel = SEL_RF;
        if (produces(ex_s, rs, used))
            sel = SEL_MEM;
        else if (produces(mem_s, rs, used))
            sel = SEL_WB;
`ifdef FWD_WB_BYPASS_EN
        else if (produces(wb_s, rs, used))
            sel = SEL_BYP;
`endif
        return sel;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        id_slot = '{valid: 1'b1, rd: id_rd, we: id_rd_we, is_load: id_is_load};
        sel_a   = pick(ex_q, mem_q, wb_q, id_rs1, id_rs1_used);
        sel_b   = pick(ex_q, mem_q, wb_q, id_rs2, id_rs2_used);
        stall   = id_valid && !flush && ex_q.is_load &&
                  (produces(ex_q, id_rs1, id_rs1_used) || produces(ex_q, id_rs2, id_rs2_used));
        issue   = id_valid && !flush && !stall;
    end

    // NOTE: sequential state uses non-blocking assignments so the slot shift reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwdA_sel  <= SEL_RF;
            fwdB_sel  <= SEL_RF;
            stall_cnt <= '0;
        end else if (!hold) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (issue) begin
                ex_q     <= id_slot;
                fwdA_sel <= sel_a;
                fwdB_sel <= sel_b;
            end else begin
                ex_q     <= '0;
                fwdA_sel <= SEL_RF;
                fwdB_sel <= SEL_RF;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNTWIDTH'(1);
        end
    end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Table-driven bench for operand_fwd_ctrl: per-cycle ID vectors with expected stall,
// and a scoreboard queue of expected registered selects/counter popped after each edge.
module tb_operand_fwd_ctrl;

    localparam int REGADDR  = 5;
    localparam int CNTWIDTH = 4;

`ifdef FWD_WB_BYPASS_EN
    localparam logic [1:0] WBC = 2'b11;
`else
    localparam logic [1:0] WBC = 2'b00;
`endif

    logic                clk = 1'b0;
    logic                rst, id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
    logic                hold, flush;
    logic [REGADDR-1:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]          fwdA_sel, fwdB_sel;
    logic                stall;
    logic [CNTWIDTH-1:0] stall_cnt;

    operand_fwd_ctrl #(.REGADDR(REGADDR), .CNTWIDTH(CNTWIDTH)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
        .hold(hold), .flush(flush),
        .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
        .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst, hold, flush, vld;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we, ld;
        logic       e_stall;
        logic [1:0] e_a, e_b;
        logic [3:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic [1:0] a, b;
        logic [3:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, h, f, v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic we, ld, st, input logic [1:0] a, b,
                                input logic [3:0] cnt);
        return '{r, h, f, v, rs1, u1, rs2, u2, rd, we, ld, st, a, b, cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        // rst hold flush vld | rs1 u1 rs2 u2 | rd we ld | stall a b cnt
        vecs.push_back(mk(1,0,0,0,  0,0, 0,0,  0,0,0, 0,2'b00,2'b00,0));  // reset
        vecs.push_back(mk(0,0,0,1,  1,1, 2,1,  5,1,0, 0,2'b00,2'b00,0));  // add x5
        vecs.push_back(mk(0,0,0,1,  5,1, 6,1, 10,1,0, 0,2'b01,2'b00,0));  // sub rs1=x5
        vecs.push_back(mk(0,0,0,1,  0,0, 0,0,  7,1,0, 0,2'b00,2'b00,0));  // producer x7
        vecs.push_back(mk(0,0,0,1, 12,1,13,1, 11,1,0, 0,2'b00,2'b00,0));  // unrelated
        vecs.push_back(mk(0,0,0,1,  7,1, 7,1, 12,1,0, 0,2'b10,2'b10,0));  // distance 2, rs1==rs2
        vecs.push_back(mk(0,0,0,1, 11,1, 7,1,  0,0,0, 0,2'b10,WBC,  0));  // distance 3 on rs2
        vecs.push_back(mk(0,0,0,1,  0,0, 0,0,  0,1,0, 0,2'b00,2'b00,0));  // writes x0
        vecs.push_back(mk(0,0,0,1,  0,1, 0,1,  9,1,0, 0,2'b00,2'b00,0));  // reads x0
        vecs.push_back(mk(0,0,0,1,  0,0, 0,0,  9,1,0, 0,2'b00,2'b00,0));  // second x9
        vecs.push_back(mk(0,0,0,1,  9,1, 9,0, 13,1,0, 0,2'b01,2'b00,0));  // nearest x9 wins
        vecs.push_back(mk(0,0,0,1, 13,1, 0,0,  3,1,1, 0,2'b01,2'b00,0));  // lw x3
        vecs.push_back(mk(0,0,0,1,  0,0, 3,1, 14,1,0, 1,2'b00,2'b00,1));  // load-use stall
        vecs.push_back(mk(0,0,0,1,  0,0, 3,1, 14,1,0, 0,2'b00,2'b10,1));  // resolves to 10
        vecs.push_back(mk(0,0,0,1, 14,1, 0,0,  4,1,1, 0,2'b01,2'b00,1));  // lw x4, fwd rs1
        for (int i = 0; i < 3; i++)                                         // hold x3
            vecs.push_back(mk(0,1,0,1, 4,1, 0,0, 15,1,0, 1,2'b01,2'b00,1));
        vecs.push_back(mk(0,0,0,1,  4,1, 0,0, 15,1,0, 1,2'b00,2'b00,2));  // stall after hold
        vecs.push_back(mk(0,0,0,1,  4,1, 0,0, 15,1,0, 0,2'b10,2'b00,2));
        vecs.push_back(mk(0,0,0,1,  0,0, 0,0,  6,1,1, 0,2'b00,2'b00,2));  // lw x6
        vecs.push_back(mk(0,0,1,1,  6,1, 0,0, 16,1,0, 0,2'b00,2'b00,2));  // flush kills stall
        vecs.push_back(mk(0,0,0,1,  6,1,15,1, 17,1,0, 0,2'b10,WBC,  2));  // MEM + WB at once
        vecs.push_back(mk(0,1,1,1, 17,1, 0,0, 18,1,0, 0,2'b10,WBC,  2));  // hold beats flush
        vecs.push_back(mk(0,0,1,1, 17,1, 0,0, 18,1,0, 0,2'b00,2'b00,2));  // flush applies
        vecs.push_back(mk(0,0,0,0, 17,1, 0,0, 18,1,0, 0,2'b00,2'b00,2));  // invalid ID
        vecs.push_back(mk(0,0,0,1,  0,0, 0,0,  8,1,0, 0,2'b00,2'b00,2));  // producer x8
        vecs.push_back(mk(0,0,0,1,  8,1, 0,0, 19,1,0, 0,2'b01,2'b00,2));
        vecs.push_back(mk(1,0,0,1, 19,1, 0,0, 20,1,0, 0,2'b00,2'b00,0));  // reset mid-stream
        vecs.push_back(mk(0,0,0,1, 19,1, 8,1, 21,1,0, 0,2'b00,2'b00,0));  // tracking gone
        // Saturation: 20 load-use stalls, counter pins at 4'hF.
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            vecs.push_back(mk(0,0,0,1, 0,0, 0,0, 3,1,1, 0,2'b00,2'b00,4'(cnt)));
            cnt = (k > 15) ? 15 : k;
            vecs.push_back(mk(0,0,0,1, 3,1, 0,0, 0,0,0, 1,2'b00,2'b00,4'(cnt)));
            vecs.push_back(mk(0,0,0,1, 3,1, 0,0, 0,0,0, 0,2'b10,2'b00,4'(cnt)));
        end

        rst = 1'b1; hold = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            exp_t e;
            v = vecs[i];
            rst = v.rst; hold = v.hold; flush = v.flush; id_valid = v.vld;
            id_rs1 = v.rs1; id_rs1_used = v.u1; id_rs2 = v.rs2; id_rs2_used = v.u2;
            id_rd = v.rd; id_rd_we = v.we; id_is_load = v.ld;
            sb.push_back('{v.e_a, v.e_b, v.e_cnt});
            @(negedge clk);
            check($sformatf("stall[%0d]", i), 32'(stall), 32'(v.e_stall));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("fwdA_sel[%0d]", i), 32'(fwdA_sel), 32'(e.a));
            check($sformatf("fwdB_sel[%0d]", i), 32'(fwdB_sel), 32'(e.b));
            check($sformatf("stall_cnt[%0d]", i), 32'(stall_cnt), 32'(e.cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
